// File: rtl/pe_array_pkg.sv
// Shared types and helpers for the row-stationary PE array convolution engine.
package pe_array_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD_W  = 2'd1,
        COMPUTE = 2'd2
    } state_e;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ACC_W  = 32;

    typedef logic signed [DEF_DATA_W-1:0] data_t;
    typedef logic signed [DEF_ACC_W-1:0]  acc_t;

    // Low bit of lane idx inside a flat vector of lanes that are w bits wide.
    function automatic int lane_lo(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/pe_array_conv_engine_pe_mac_cell.sv
// One PE: a stationary weight register and a psum register that accumulates the
// psum from below plus x*w whenever the array advances.
module pe_mac_cell #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [DATA_W-1:0] w_in,
    input  logic              adv,
    input  logic [DATA_W-1:0] x_in,
    input  logic [ACC_W-1:0]  psum_in,
    output logic [ACC_W-1:0]  psum
);

    logic signed [DATA_W-1:0]   w_q;
    logic signed [2*DATA_W-1:0] prod;

    // Full-width signed product; the size cast below sign-extends into the psum.
    assign prod = $signed(x_in) * w_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            w_q  <= '0;
            psum <= '0;
        end else begin
            if (load_en) begin
                w_q <= $signed(w_in);
            end
            if (adv) begin
                psum <= psum_in + ACC_W'(prod);
            end
        end
    end

endmodule

// File: rtl/pe_array_conv_engine.sv
// ROWS x COLS row-stationary PE array with weight-load / compute control FSM.
// Handshake: a transfer happens on a rising clk edge where valid & ready are both 1.
module pe_array_conv_engine
    import pe_array_pkg::*;
#(
    parameter int ROWS   = 12,
    parameter int COLS   = 14,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32,
    parameter int LEN_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    cfg_reload,
    input  logic [LEN_W-1:0]        cfg_len,
    input  logic                    w_valid,
    output logic                    w_ready,
    input  logic [COLS*DATA_W-1:0]  w_row,
    input  logic                    x_valid,
    output logic                    x_ready,
    input  logic [COLS*DATA_W-1:0]  x_vec,
    input  logic [COLS*ACC_W-1:0]   bias_vec,
    output logic                    y_valid,
    input  logic                    y_ready,
    output logic [COLS*ACC_W-1:0]   y_vec,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output state_e                  state
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int FW = $clog2(ROWS + 1);

    state_e           state_d;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] x_cnt;
    logic [LEN_W-1:0] out_cnt;
    logic [RW-1:0]    w_cnt;
    logic [FW-1:0]    fill;

    logic len_short;
    logic w_acc;
    logic advance;
    logic y_hs;
    logic job_go;
    logic [ROWS-1:0] load_en;

    assign len_short = (cfg_len < LEN_W'(ROWS));
    assign job_go    = (state == IDLE) && start && !len_short;
    assign w_acc     = w_valid && w_ready;
    assign advance   = x_valid && x_ready;
    assign y_hs      = y_valid && y_ready;
    assign busy      = (state != IDLE);

    always_comb begin
        state_d = state;
        w_ready = 1'b0;
        x_ready = 1'b0;
        done    = 1'b0;
        err     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (len_short) begin
                        done = 1'b1;
                        err  = 1'b1;
                    end else begin
                        state_d = cfg_reload ? LOAD_W : COMPUTE;
                    end
                end
            end
            LOAD_W: begin
                w_ready = 1'b1;
                if (w_valid && (w_cnt == RW'(ROWS - 1))) begin
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                // The array only moves when the top-row result has been consumed or is empty.
                x_ready = (x_cnt < len_q) && (!y_valid || y_ready);
                if (y_hs && (out_cnt == len_q - LEN_W'(ROWS))) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            done = 1'b0;
            err  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            len_q   <= '0;
            x_cnt   <= '0;
            out_cnt <= '0;
            w_cnt   <= '0;
            fill    <= '0;
            y_valid <= 1'b0;
        end else begin
            state <= state_d;
            if (job_go) begin
                len_q   <= cfg_len;
                x_cnt   <= '0;
                out_cnt <= '0;
                w_cnt   <= '0;
                fill    <= '0;
                y_valid <= 1'b0;
            end else begin
                if (w_acc) begin
                    w_cnt <= w_cnt + RW'(1);
                end
                if (advance) begin
                    x_cnt <= x_cnt + LEN_W'(1);
                    if (fill != FW'(ROWS)) begin
                        fill <= fill + FW'(1);
                    end
                end
                // A new window reaches the top row on every advance once the pipe is full.
                if (advance && (fill >= FW'(ROWS - 1))) begin
                    y_valid <= 1'b1;
                end else if (y_hs) begin
                    y_valid <= 1'b0;
                end
                if (y_hs) begin
                    out_cnt <= out_cnt + LEN_W'(1);
                end
            end
        end
    end

    logic [ACC_W-1:0] psum [ROWS][COLS];

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        assign load_en[r] = w_acc && (w_cnt == RW'(r));

        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic [ACC_W-1:0] below;

            if (r == ROWS - 1) begin : g_bot
                assign below = bias_vec[lane_lo(c, ACC_W) +: ACC_W];
            end else begin : g_mid
                assign below = psum[r+1][c];
            end

            pe_mac_cell #(
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W)
            ) u_cell (
                .clk     (clk),
                .rst     (rst),
                .load_en (load_en[r]),
                .w_in    (w_row[lane_lo(c, DATA_W) +: DATA_W]),
                .adv     (advance),
                .x_in    (x_vec[lane_lo(c, DATA_W) +: DATA_W]),
                .psum_in (below),
                .psum    (psum[r][c])
            );
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_out
        assign y_vec[lane_lo(c, ACC_W) +: ACC_W] = psum[0][c];
    end

endmodule

// File: tb/tb_pe_array_conv_engine.sv
// Bench for pe_array_conv_engine: table of jobs checked through an expected-output
// queue, plus hand-written error-start and mid-job reset sequences.
module tb_pe_array_conv_engine;
    import pe_array_pkg::*;

    localparam int ROWS   = 3;
    localparam int COLS   = 4;
    localparam int DATA_W = 16;
    localparam int ACC_W  = 32;
    localparam int LEN_W  = 16;
    localparam int YW     = COLS * ACC_W;
    localparam int XW     = COLS * DATA_W;
    localparam int MAXLEN = 16;

    logic             clk;
    logic             rst;
    logic             start;
    logic             cfg_reload;
    logic [LEN_W-1:0] cfg_len;
    logic             w_valid;
    logic             w_ready;
    logic [XW-1:0]    w_row;
    logic             x_valid;
    logic             x_ready;
    logic [XW-1:0]    x_vec;
    logic [YW-1:0]    bias_vec;
    logic             y_valid;
    logic             y_ready;
    logic [YW-1:0]    y_vec;
    logic             busy;
    logic             done;
    logic             err;
    state_e           state;

    pe_array_conv_engine #(
        .ROWS (ROWS), .COLS (COLS), .DATA_W (DATA_W), .ACC_W (ACC_W), .LEN_W (LEN_W)
    ) dut (
        .clk (clk), .rst (rst), .start (start), .cfg_reload (cfg_reload), .cfg_len (cfg_len),
        .w_valid (w_valid), .w_ready (w_ready), .w_row (w_row),
        .x_valid (x_valid), .x_ready (x_ready), .x_vec (x_vec), .bias_vec (bias_vec),
        .y_valid (y_valid), .y_ready (y_ready), .y_vec (y_vec),
        .busy (busy), .done (done), .err (err), .state (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit reload;
        int len;
        int wk;        // 0 ramp r+1, 1 random, 2 max positive
        int xk;        // 0 ramp k+1, 1 random, 2 max positive
        int bk;        // 0 constant bias, 1 random bias
        int bias;
        int stall_at;  // output index where y_ready is held low
        int stall_len;
    } job_t;

    int total = 0;
    int bad   = 0;
    logic [YW-1:0] exp_q[$];

    logic signed [DATA_W-1:0] w_m [ROWS][COLS];
    logic signed [DATA_W-1:0] x_m [MAXLEN][COLS];
    logic signed [ACC_W-1:0]  b_m [MAXLEN][COLS];

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic checkv(input string name, input logic [YW-1:0] act, input logic [YW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [XW-1:0] pack_w(input int k);
        logic [XW-1:0] v;
        for (int c = 0; c < COLS; c++) v[c*DATA_W +: DATA_W] = w_m[k][c];
        return v;
    endfunction

    function automatic logic [XW-1:0] pack_x(input int k);
        logic [XW-1:0] v;
        for (int c = 0; c < COLS; c++) v[c*DATA_W +: DATA_W] = x_m[k][c];
        return v;
    endfunction

    function automatic logic [YW-1:0] pack_b(input int k);
        logic [YW-1:0] v;
        for (int c = 0; c < COLS; c++) v[c*ACC_W +: ACC_W] = b_m[k][c];
        return v;
    endfunction

    function automatic logic [DATA_W-1:0] gen_val(input int kind, input int idx);
        if (kind == 0) return DATA_W'(idx + 1);
        if (kind == 2) return 16'h7FFF;
        return DATA_W'($urandom_range(0, 65535));
    endfunction

    // Fills the stimulus model and pushes y[t][c] = bias[t][c] + sum_r w[r][c]*x[t+ROWS-1-r][c].
    task automatic build(input job_t j);
        logic [YW-1:0] v;
        logic signed [ACC_W-1:0] s;
        if (j.reload)
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) w_m[r][c] = gen_val(j.wk, r);
        for (int k = 0; k < j.len; k++)
            for (int c = 0; c < COLS; c++) begin
                x_m[k][c] = gen_val(j.xk, k);
                b_m[k][c] = (j.bk == 1) ? ACC_W'($urandom()) : ACC_W'(j.bias);
            end
        for (int t = 0; t <= j.len - ROWS; t++) begin
            for (int c = 0; c < COLS; c++) begin
                s = b_m[t][c];
                for (int r = 0; r < ROWS; r++) s = s + w_m[r][c] * x_m[t+ROWS-1-r][c];
                v[c*ACC_W +: ACC_W] = s;
            end
            exp_q.push_back(v);
        end
    endtask

    task automatic load_weights(input string tag);
        int k = 0;
        int cyc = 0;
        while (k < ROWS && cyc < 50) begin
            w_valid = 1'b1;
            w_row   = pack_w(k);
            #1;
            check1({tag, "_load_xready"}, x_ready, 1'b0);
            if (w_ready) k++;
            @(negedge clk);
            cyc++;
        end
        w_valid = 1'b0;
        if (k < ROWS) begin
            bad++;
            total++;
            $display("FAIL %s_load_timeout: got %0d rows want %0d", tag, k, ROWS);
        end
    endtask

    task automatic run_job(input job_t j, input string tag);
        int xi = 0;
        int yo = 0;
        int cyc = 0;
        int st_done = 0;
        int nout;
        bit stalling;
        bit held_ok = 0;
        bit w_seen = 0;
        logic [YW-1:0] held;
        logic [YW-1:0] e;
        logic hs;
        build(j);
        nout = j.len - ROWS + 1;
        @(negedge clk);
        start = 1'b1; cfg_reload = j.reload; cfg_len = LEN_W'(j.len);
        #1;
        check1({tag, "_start_err"}, err, 1'b0);
        @(negedge clk);
        start = 1'b0;
        if (j.reload) load_weights(tag);
        while (yo < nout && cyc < 200) begin
            x_valid  = (xi < j.len);
            x_vec    = x_valid ? pack_x(xi) : '0;
            bias_vec = x_valid ? pack_b(xi) : '0;
            stalling = (j.stall_len > 0) && (yo == j.stall_at) && (st_done < j.stall_len);
            y_ready  = !stalling;
            #1;
            if (w_ready) w_seen = 1;
            if (stalling && y_valid) begin
                st_done++;
                check1({tag, "_stall_xready"}, x_ready, 1'b0);
                if (held_ok) checkv({tag, "_stall_hold"}, y_vec, held);
                held    = y_vec;
                held_ok = 1;
            end else begin
                held_ok = 0;
            end
            hs = y_valid && y_ready;
            check1({tag, "_done"}, done, hs && (yo == nout - 1));
            if (hs) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL %s_extra_output: got %h want none", tag, y_vec);
                end else begin
                    e = exp_q.pop_front();
                    checkv({tag, "_y"}, y_vec, e);
                end
                yo++;
            end
            if (x_valid && x_ready) xi++;
            @(negedge clk);
            cyc++;
        end
        x_valid = 1'b0;
        y_ready = 1'b1;
        if (yo < nout) begin
            total++; bad++;
            $display("FAIL %s_timeout: got %0d outputs want %0d", tag, yo, nout);
        end
        #1;
        check1({tag, "_idle_busy"}, busy, 1'b0);
        check1({tag, "_idle_done"}, done, 1'b0);
        check1({tag, "_x_count"}, xi == j.len, 1'b1);
        check1({tag, "_no_wready"}, w_seen, 1'b0);
        check1({tag, "_queue_empty"}, exp_q.size() == 0, 1'b1);
        exp_q.delete();
    endtask

    job_t jobs[6];

    initial begin
        jobs[0] = '{reload: 1, len: 5, wk: 0, xk: 0, bk: 0, bias: 0,   stall_at: -1, stall_len: 0};
        jobs[1] = '{reload: 0, len: 5, wk: 0, xk: 0, bk: 0, bias: 100, stall_at: -1, stall_len: 0};
        jobs[2] = '{reload: 0, len: 6, wk: 0, xk: 0, bk: 0, bias: 0,   stall_at: 1,  stall_len: 4};
        jobs[3] = '{reload: 1, len: 8, wk: 1, xk: 1, bk: 1, bias: 0,   stall_at: -1, stall_len: 0};
        jobs[4] = '{reload: 1, len: 3, wk: 2, xk: 2, bk: 0, bias: 0,   stall_at: -1, stall_len: 0};
        jobs[5] = '{reload: 1, len: 7, wk: 1, xk: 1, bk: 1, bias: 0,   stall_at: 0,  stall_len: 3};

        rst = 1'b1; start = 1'b0; cfg_reload = 1'b0; cfg_len = '0;
        w_valid = 1'b0; w_row = '0; x_valid = 1'b0; x_vec = '0; bias_vec = '0; y_ready = 1'b1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) w_m[r][c] = '0;
        repeat (3) @(negedge clk);
        #1;
        check1("rst_busy", busy, 1'b0);
        check1("rst_done", done, 1'b0);
        check1("rst_err", err, 1'b0);
        check1("rst_w_ready", w_ready, 1'b0);
        check1("rst_x_ready", x_ready, 1'b0);
        check1("rst_y_valid", y_valid, 1'b0);
        check1("rst_state", state == IDLE, 1'b1);
        checkv("rst_y_vec", y_vec, '0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_job(jobs[i], $sformatf("job%0d", i));

        // Too-short job: flagged and dropped in the same cycle.
        @(negedge clk);
        start = 1'b1; cfg_reload = 1'b1; cfg_len = LEN_W'(2);
        #1;
        check1("short_done", done, 1'b1);
        check1("short_err", err, 1'b1);
        check1("short_busy", busy, 1'b0);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check1("short_state", state == IDLE, 1'b1);
            check1("short_w_ready", w_ready, 1'b0);
            check1("short_x_ready", x_ready, 1'b0);
            check1("short_done_after", done, 1'b0);
            @(negedge clk);
        end

        // Abort mid-compute, then a reuse job must see cleared weights.
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) w_m[r][c] = gen_val(1, r);
        start = 1'b1; cfg_reload = 1'b1; cfg_len = LEN_W'(5);
        @(negedge clk);
        start = 1'b0;
        load_weights("abort");
        y_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            x_valid = 1'b1; x_vec = pack_w(k % ROWS); bias_vec = '0;
            @(negedge clk);
        end
        x_valid = 1'b0;
        #1;
        check1("abort_busy_before", busy, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check1("abort_rst_done", done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        y_ready = 1'b1;
        #1;
        check1("abort_state", state == IDLE, 1'b1);
        check1("abort_y_valid", y_valid, 1'b0);
        checkv("abort_y_vec", y_vec, '0);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) w_m[r][c] = '0;
        run_job('{reload: 0, len: 5, wk: 0, xk: 1, bk: 1, bias: 0, stall_at: -1, stall_len: 0}, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
